// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA raster generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} vga_region_t;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sw, input int unsigned bp);
    return vis + fp + sw + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sw, input int unsigned bp);
    return vis + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter advanced by inc, with a decode of the region
// (visible / front porch / sync / back porch) that the current count falls in.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter  int unsigned VIS_LEN  = 640,
  parameter  int unsigned FP_LEN   = 16,
  parameter  int unsigned SYNC_LEN = 96,
  parameter  int unsigned BP_LEN   = 48,
  localparam int unsigned TOTAL    = VIS_LEN + FP_LEN + SYNC_LEN + BP_LEN,
  localparam int unsigned W        = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output vga_region_t  region
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(VIS_LEN);
  localparam logic [W-1:0] SYNC_START = W'(VIS_LEN + FP_LEN);
  localparam logic [W-1:0] BP_START   = W'(VIS_LEN + FP_LEN + SYNC_LEN);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (inc) begin
      if (count_q == LAST) begin
        count_d = {W{1'b0}};
        wrap    = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  always_comb begin
    if (count_q < FP_START) begin
      region = VISIBLE;
    end else if (count_q < SYNC_START) begin
      region = FRONT;
    end else if (count_q < BP_START) begin
      region = SYNC;
    end else begin
      region = BACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered sync/blank/coordinate/strobe outputs one ce behind the counters.
// Define VGA_TIMING_PATTERN_EN to add an 8-bar colour test pattern on red/green/blue.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter  int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter  int unsigned H_FRONT   = DEF_H_FRONT,
  parameter  int unsigned H_SYNC    = DEF_H_SYNC,
  parameter  int unsigned H_BACK    = DEF_H_BACK,
  parameter  int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter  int unsigned V_FRONT   = DEF_V_FRONT,
  parameter  int unsigned V_SYNC    = DEF_V_SYNC,
  parameter  int unsigned V_BACK    = DEF_V_BACK,
  parameter  int unsigned H_POL     = 0,
  parameter  int unsigned V_POL     = 0,
  localparam int unsigned H_TOTAL   = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int unsigned V_TOTAL   = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int unsigned XW        = $clog2(H_TOTAL),
  localparam int unsigned YW        = $clog2(V_TOTAL)
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue
);

  localparam logic H_ACT = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic V_ACT = (V_POL != 0) ? 1'b1 : 1'b0;

  logic [XW-1:0] hc;
  logic [YW-1:0] vc;
  logic          h_wrap, v_wrap_unused;
  vga_region_t   h_region, v_region;

  vga_axis_counter #(
    .VIS_LEN(H_VISIBLE), .FP_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BP_LEN(H_BACK)
  ) u_h_axis (
    .clk(clk_pixel), .rst_n(rst_n), .inc(ce),
    .count(hc), .wrap(h_wrap), .region(h_region)
  );

  vga_axis_counter #(
    .VIS_LEN(V_VISIBLE), .FP_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BP_LEN(V_BACK)
  ) u_v_axis (
    .clk(clk_pixel), .rst_n(rst_n), .inc(ce & h_wrap),
    .count(vc), .wrap(v_wrap_unused), .region(v_region)
  );

  logic [XW-1:0] x_d, x_q;
  logic [YW-1:0] y_d, y_q;
  logic          hsync_d, hsync_q, vsync_d, vsync_q, blank_d, blank_q;
  logic          line_start_d, line_start_q, frame_start_d, frame_start_q;

  // Decode the pre-advance counter values; everything holds while ce is low.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (ce) begin
      x_d           = hc;
      y_d           = vc;
      hsync_d       = (h_region == SYNC) ? H_ACT : ~H_ACT;
      vsync_d       = (v_region == SYNC) ? V_ACT : ~V_ACT;
      blank_d       = (h_region != VISIBLE) || (v_region != VISIBLE);
      line_start_d  = (hc == {XW{1'b0}});
      frame_start_d = (hc == {XW{1'b0}}) && (vc == {YW{1'b0}});
    end else begin
      x_d = x_q;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= {XW{1'b0}};
      y_q           <= {YW{1'b0}};
      hsync_q       <= ~H_ACT;
      vsync_q       <= ~V_ACT;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_PATTERN_EN
  localparam logic [XW-1:0] BAR_W = XW'(H_VISIBLE / 8);

  logic [2:0]  bar_s;
  logic [23:0] rgb_d, rgb_q;

  // Bar index picks one bit per colour channel; forced dark outside the visible area.
  always_comb begin
    bar_s = 3'(hc / BAR_W);
    rgb_d = rgb_q;
    if (ce) begin
      if ((h_region == VISIBLE) && (v_region == VISIBLE)) begin
        rgb_d = {{8{bar_s[2]}}, {8{bar_s[1]}}, {8{bar_s[0]}}};
      end else begin
        rgb_d = 24'h000000;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];
`else
  assign red   = 8'h00;
  assign green = 8'h00;
  assign blue  = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a small-raster instance and a default 640x480 instance checked
// against an arithmetic raster model, plus a table of default-mode landmarks.
module tb_vga_timing_gen;

  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 12, SVF = 3, SVS = 2, SVB = 4;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;

`ifdef VGA_TIMING_PATTERN_EN
  localparam logic [23:0] BLUE_PIX  = 24'h0000FF;
  localparam logic [23:0] WHITE_PIX = 24'hFFFFFF;
`else
  localparam logic [23:0] BLUE_PIX  = 24'h000000;
  localparam logic [23:0] WHITE_PIX = 24'h000000;
`endif

  logic clk_pixel = 1'b0;
  logic rst_n     = 1'b0;
  logic ce        = 1'b0;

  logic       s_hsync, s_vsync, s_blank, s_ls, s_fs;
  logic [4:0] s_x, s_y;
  logic [7:0] s_r, s_g, s_b;
  logic       d_hsync, d_vsync, d_blank, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_r, d_g, d_b;

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .H_POL(1), .V_POL(0)
  ) dut_s (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .ce(ce),
    .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .red(s_r), .green(s_g), .blue(s_b)
  );

  vga_timing_gen dut_d (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .ce(ce),
    .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .red(d_r), .green(d_g), .blue(d_b)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        ls;
    logic        fs;
    logic [23:0] rgb;
  } obs_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int nk       = 0;  // number of ce pulses accepted since the last reset

  // Expected outputs after k accepted ce pulses, from the raster rules alone.
  function automatic obs_t ref_out(input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp, input int k);
    obs_t o;
    int ht, vt, p, px, py, b;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    o  = '0;
    if (k == 0) begin
      o.hs = ~hp;
      o.vs = ~vp;
      o.bl = 1'b1;
      return o;
    end
    p  = k - 1;
    px = p % ht;
    py = (p / ht) % vt;
    o.x  = 10'(px);
    o.y  = 10'(py);
    o.hs = (px >= hv + hf && px < hv + hf + hsw) ? hp : ~hp;
    o.vs = (py >= vv + vf && py < vv + vf + vsw) ? vp : ~vp;
    o.bl = (px >= hv || py >= vv);
    o.ls = (px == 0);
    o.fs = (px == 0 && py == 0);
`ifdef VGA_TIMING_PATTERN_EN
    if (!o.bl) begin
      b = px / (hv / 8);
      o.rgb = {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    end
`endif
    b = 0;
    return o;
  endfunction

  function automatic obs_t mk(input int x, input int y, input bit hs, input bit vs, input bit bl,
                              input bit ls, input bit fs, input logic [23:0] rgb);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y); o.hs = hs; o.vs = vs; o.bl = bl;
    o.ls = ls; o.fs = fs; o.rgb = rgb;
    return o;
  endfunction

  function automatic obs_t obs_s();
    obs_t o;
    o.x = {5'b0, s_x}; o.y = {5'b0, s_y}; o.hs = s_hsync; o.vs = s_vsync; o.bl = s_blank;
    o.ls = s_ls; o.fs = s_fs; o.rgb = {s_r, s_g, s_b};
    return o;
  endfunction

  function automatic obs_t obs_d();
    obs_t o;
    o.x = d_x; o.y = d_y; o.hs = d_hsync; o.vs = d_vsync; o.bl = d_blank;
    o.ls = d_ls; o.fs = d_fs; o.rgb = {d_r, d_g, d_b};
    return o;
  endfunction

  task automatic cmp_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b rgb=%h, expected x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b rgb=%h",
               name, nk, act.x, act.y, act.hs, act.vs, act.bl, act.ls, act.fs, act.rgb,
               exp.x, exp.y, exp.hs, exp.vs, exp.bl, exp.ls, exp.fs, exp.rgb);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_both();
    cmp_obs("small", obs_s(), ref_out(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1, 1'b0, nk));
    cmp_obs("default", obs_d(), ref_out(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, nk));
  endtask

  task automatic tick(input logic c);
    ce = c;
    @(posedge clk_pixel);
    if (c && rst_n) nk++;
    #1;
    check_both();
  endtask

  task automatic wait_out(input int tx, input int ty, input int budget);
    int n;
    n = 0;
    while (!(s_x == 5'(tx) && s_y == 5'(ty)) && n < budget) begin
      tick(1'b1);
      n++;
    end
    cmp_int($sformatf("reach_%0d_%0d", tx, ty), (n < budget) ? 1 : 0, 1);
  endtask

  vec_t tab[14];

  initial begin
    int nls, nfs, run, nruns, last_rise, cyc;
    logic prev_fs;

    tab[0]  = '{k: 1,   exp: mk(0,   0, 1, 1, 0, 1, 1, 24'h000000)};
    tab[1]  = '{k: 2,   exp: mk(1,   0, 1, 1, 0, 0, 0, 24'h000000)};
    tab[2]  = '{k: 80,  exp: mk(79,  0, 1, 1, 0, 0, 0, 24'h000000)};
    tab[3]  = '{k: 81,  exp: mk(80,  0, 1, 1, 0, 0, 0, BLUE_PIX)};
    tab[4]  = '{k: 601, exp: mk(600, 0, 1, 1, 0, 0, 0, WHITE_PIX)};
    tab[5]  = '{k: 640, exp: mk(639, 0, 1, 1, 0, 0, 0, WHITE_PIX)};
    tab[6]  = '{k: 641, exp: mk(640, 0, 1, 1, 1, 0, 0, 24'h000000)};
    tab[7]  = '{k: 656, exp: mk(655, 0, 1, 1, 1, 0, 0, 24'h000000)};
    tab[8]  = '{k: 657, exp: mk(656, 0, 0, 1, 1, 0, 0, 24'h000000)};
    tab[9]  = '{k: 701, exp: mk(700, 0, 0, 1, 1, 0, 0, 24'h000000)};
    tab[10] = '{k: 752, exp: mk(751, 0, 0, 1, 1, 0, 0, 24'h000000)};
    tab[11] = '{k: 753, exp: mk(752, 0, 1, 1, 1, 0, 0, 24'h000000)};
    tab[12] = '{k: 800, exp: mk(799, 0, 1, 1, 1, 0, 0, 24'h000000)};
    tab[13] = '{k: 801, exp: mk(0,   1, 1, 1, 0, 1, 0, 24'h000000)};

    // Reset state, with clocks running and ce toggling
    for (int i = 0; i < 4; i++) tick(1'(i % 2));
    rst_n = 1'b1;

    // Default-mode landmarks with ce held high
    for (int i = 0; i < 14; i++) begin
      int guard;
      guard = 0;
      while (nk < tab[i].k && guard < 2000) begin
        tick(1'b1);
        guard++;
      end
      cmp_obs($sformatf("table%0d", i), obs_d(), tab[i].exp);
    end

    // Random ce against the model
    for (int i = 0; i < 3000; i++) tick(1'($urandom_range(0, 2) != 0));

    // One full small frame of ce=1: line/frame strobe counts
    nls = 0;
    nfs = 0;
    for (int i = 0; i < SHT * SVT; i++) begin
      tick(1'b1);
      nls += int'(s_ls);
      nfs += int'(s_fs);
    end
    cmp_int("line_start_count", nls, SVT);
    cmp_int("frame_start_count", nfs, 1);

    // Wrap boundaries observed through the outputs
    wait_out(SHT - 1, SVT - 1, 2 * SHT * SVT);
    tick(1'b1);
    cmp_int("frame_wrap", int'({s_x, s_y, s_ls, s_fs}), int'({5'd0, 5'd0, 1'b1, 1'b1}));
    wait_out(SHT - 1, 5, 2 * SHT * SVT);
    tick(1'b1);
    cmp_int("line_wrap", int'({s_x, s_y, s_ls, s_fs}), int'({5'd0, 5'd6, 1'b1, 1'b0}));

    // ce one-in-ten: strobes last 10 clocks, frame period 10x the raster
    run = 0;
    nruns = 0;
    last_rise = -1;
    cyc = 0;
    prev_fs = s_fs;
    for (int i = 0; i < 2 * 10 * SHT * SVT + 40; i++) begin
      tick(1'(i % 10 == 0));
      cyc++;
      if (s_ls) begin
        run++;
      end else if (run > 0) begin
        cmp_int("line_start_width", run, 10);
        run = 0;
        nruns++;
      end
      if (s_fs && !prev_fs) begin
        if (last_rise >= 0) cmp_int("frame_period", cyc - last_rise, 10 * SHT * SVT);
        last_rise = cyc;
      end
      prev_fs = s_fs;
    end
    cmp_int("line_start_runs_seen", (nruns >= 2 * SVT) ? 1 : 0, 1);

    // Asynchronous reset mid-frame, then restart from the origin
    wait_out(10, 7, 2 * SHT * SVT);
    #2;
    rst_n = 1'b0;
    #1;
    nk = 0;
    check_both();
    for (int i = 0; i < 3; i++) tick(1'b1);
    rst_n = 1'b1;
    tick(1'b1);
    cmp_int("restart", int'({s_x, s_y, s_blank, s_ls, s_fs}),
            int'({5'd0, 5'd0, 1'b0, 1'b1, 1'b1}));
    for (int i = 0; i < 50; i++) tick(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
